despacha_halt: RTL and testbench

// - CPU-side counterpart of the OS/BIOS mode controller: turns a decoded HALT instruction into the HALT

---
 rtl/despacha_halt_pkg.sv | 18 +
 rtl/despacha_halt_debounce_botao.sv | 52 +++++
 rtl/despacha_halt.sv | 133 +++++++++++++
 tb/tb_despacha_halt.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/despacha_halt_pkg.sv
// despacha_halt_pkg: shared FSM state encoding and reset PC constant for the HALT dispatcher.
// Rev 1.0
`default_nettype none
package despacha_halt_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    HALT_REQ = 3'd1,
    WAIT_ACK = 3'd2,
    FLUSH    = 3'd3,
    LOAD_PC  = 3'd4,
    BLOCKED  = 3'd5
  } state_t;

  localparam logic [31:0] C_OS_ENTRY = 32'h0000_0400;

endpackage
`default_nettype wire

// File: rtl/despacha_halt_debounce_botao.sv
// debounce_botao: 2-FF synchroniser, stability counter and rising-edge pulse for a bouncy button.
// Rev 1.0
`default_nettype none
module debounce_botao #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DEB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_last;
  logic          r_filt;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_last  <= 1'b0;
      r_filt  <= 1'b0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (r_sync2 != r_last) begin
        r_last <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
        // Filtered level commits as the counter reaches its full window
        if (r_cnt == C_CNT_MAX - 1'b1) begin
          r_filt  <= r_last;
          r_pulse <= r_last & ~r_filt;
        end
      end
    end
  end

  assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/despacha_halt.sv
// despacha_halt: turns a decoded HALT into the mode-controller handshake, then flushes/reloads or parks the core.
// Rev 1.0
`default_nettype none
module despacha_halt
  import despacha_halt_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] OS_ENTRY     = ADDR_W'(C_OS_ENTRY),
  parameter int                FLUSH_CYCLES = 3,
  parameter int                ACK_TIMEOUT  = 8,
  parameter int                DEB_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              halt_instr,
  input  logic              Sel_BIOS,
  input  logic              bloq_cpu,
  input  logic              resume,
  output logic              HALT,
  output logic              cpu_en,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              ack_err
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int FLS_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [ACK_W-1:0] C_ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [FLS_W-1:0] C_FLS_LAST = FLS_W'(FLUSH_CYCLES - 1);

  state_t            r_state;
  logic              r_bios_q;
  logic [ACK_W-1:0]  r_ack_cnt;
  logic [FLS_W-1:0]  r_flush_cnt;
  logic              r_halt;
  logic              r_cpu_en;
  logic              r_pc_load;
  logic [ADDR_W-1:0] r_pc_load_val;
  logic              r_ack_err;
  logic              w_resume_pulse;

  debounce_botao #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (resume),
    .pulse  (w_resume_pulse)
  );

  // Outputs are registered alongside the state they belong to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RUN;
      r_bios_q      <= 1'b0;
      r_ack_cnt     <= '0;
      r_flush_cnt   <= '0;
      r_halt        <= 1'b0;
      r_cpu_en      <= 1'b1;
      r_pc_load     <= 1'b0;
      r_pc_load_val <= '0;
      r_ack_err     <= 1'b0;
    end else begin
      r_halt        <= 1'b0;
      r_pc_load     <= 1'b0;
      r_pc_load_val <= '0;
      case (r_state)
        RUN: begin
          r_cpu_en <= 1'b1;
          if (halt_instr) begin
            r_state  <= HALT_REQ;
            r_bios_q <= Sel_BIOS;
            r_halt   <= 1'b1;
            r_cpu_en <= 1'b0;
          end
        end
        HALT_REQ: begin
          r_state   <= WAIT_ACK;
          r_ack_cnt <= '0;
          r_cpu_en  <= 1'b0;
        end
        WAIT_ACK: begin
          r_cpu_en <= 1'b0;
          if (bloq_cpu) begin
            r_state <= BLOCKED;
          end else if (Sel_BIOS != r_bios_q) begin
            r_state     <= FLUSH;
            r_flush_cnt <= '0;
          end else if (r_ack_cnt == C_ACK_LAST) begin
            r_state   <= BLOCKED;
            r_ack_err <= 1'b1;
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end
        FLUSH: begin
          r_cpu_en <= 1'b0;
          if (r_flush_cnt == C_FLS_LAST) begin
            r_state       <= LOAD_PC;
            r_pc_load     <= 1'b1;
            r_pc_load_val <= OS_ENTRY;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        LOAD_PC: begin
          r_state  <= RUN;
          r_cpu_en <= 1'b1;
        end
        BLOCKED: begin
          r_cpu_en <= 1'b0;
          if (w_resume_pulse) begin
            r_state       <= LOAD_PC;
            r_pc_load     <= 1'b1;
            r_pc_load_val <= OS_ENTRY;
          end
        end
        default: begin
          r_state  <= RUN;
          r_cpu_en <= 1'b1;
        end
      endcase
    end
  end

  assign HALT        = r_halt;
  assign cpu_en      = r_cpu_en;
  assign pc_load     = r_pc_load;
  assign pc_load_val = r_pc_load_val;
  assign ack_err     = r_ack_err;

endmodule
`default_nettype wire

// File: tb/tb_despacha_halt.sv
// tb_despacha_halt: directed and randomized handshake scenarios checked against a timeline model of the dispatcher.
// Rev 1.0
`default_nettype none
module tb_despacha_halt;

  localparam int DEB = 16;
  localparam logic [31:0] OS_ENTRY = 32'h0000_0400;

  localparam int K_SWITCH  = 0;
  localparam int K_BLOCK   = 1;
  localparam int K_BOTH    = 2;
  localparam int K_TIMEOUT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        halt_instr;
  logic        Sel_BIOS;
  logic        bloq_cpu;
  logic        resume;
  logic        HALT;
  logic        cpu_en;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        ack_err;

  int   total = 0;
  int   bad   = 0;
  logic exp_err = 1'b0;

  despacha_halt dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .halt_instr (halt_instr),
    .Sel_BIOS   (Sel_BIOS),
    .bloq_cpu   (bloq_cpu),
    .resume     (resume),
    .HALT       (HALT),
    .cpu_en     (cpu_en),
    .pc_load    (pc_load),
    .pc_load_val(pc_load_val),
    .ack_err    (ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic h, input logic en, input logic pl);
    chk({tag, ".HALT"}, 32'(HALT), 32'(h));
    chk({tag, ".cpu_en"}, 32'(cpu_en), 32'(en));
    chk({tag, ".pc_load"}, 32'(pc_load), 32'(pl));
    chk({tag, ".pc_load_val"}, pc_load_val, pl ? OS_ENTRY : 32'h0);
    chk({tag, ".ack_err"}, 32'(ack_err), 32'(exp_err));
  endtask

  // Timeline model: after the HALT pulse, WAIT_ACK spans 8 edges; a reaction presented
  // before edge 1+j decides the outcome, a switch flushes 3 cycles then loads the PC.
  task automatic run_txn(input int kind, input int j);
    int    last_e;
    string tag;
    tag = $sformatf("txn k%0d j%0d", kind, j);
    halt_instr = 1'b1;
    tick();
    chk_out({tag, " req"}, 1'b1, 1'b0, 1'b0);
    last_e = (kind == K_SWITCH) ? 5 + j : (kind == K_TIMEOUT) ? 11 : 3 + j;
    for (int e = 1; e <= last_e; e++) begin
      halt_instr = 1'($urandom_range(0, 1));
      if (kind != K_TIMEOUT && e == 1 + j) begin
        if (kind != K_BLOCK)  Sel_BIOS = ~Sel_BIOS;
        if (kind != K_SWITCH) bloq_cpu = 1'b1;
      end
      tick();
      if (kind == K_TIMEOUT && e >= 9) exp_err = 1'b1;
      if (e == 2 + j) bloq_cpu = 1'b0;
      chk_out($sformatf("%s e%0d", tag, e), 1'b0,
              (kind == K_SWITCH) && (e >= 5 + j),
              (kind == K_SWITCH) && (e == 4 + j));
    end
    halt_instr = 1'b0;
  endtask

  // Hold resume high: expect exactly one restart, no sooner than a full debounce window.
  task automatic do_resume();
    int first;
    int n;
    first  = -1;
    n      = 0;
    resume = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (pc_load === 1'b1) begin
        n++;
        if (first < 0) first = t;
        chk("resume.pc_load_val", pc_load_val, OS_ENTRY);
      end
      chk("resume.cpu_en", 32'(cpu_en), 32'((first >= 0) && (t > first)));
      chk("resume.ack_err", 32'(ack_err), 32'(exp_err));
    end
    chk("resume.count", 32'(n), 32'd1);
    chk("resume.not_early", 32'(first >= DEB), 32'd1);
    resume = 1'b0;
    for (int t = 0; t < 25; t++) begin
      tick();
      chk_out("resume.idle", 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    halt_instr = 1'b0;
    Sel_BIOS   = 1'b1;
    bloq_cpu   = 1'b0;
    resume     = 1'b0;
    repeat (3) tick();
    chk_out("reset", 1'b0, 1'b1, 1'b0);
    reset_n = 1'b1;
    tick();
    chk_out("run", 1'b0, 1'b1, 1'b0);

    // BIOS -> OS hand-off, controller answers two cycles after HALT
    run_txn(K_SWITCH, 2);

    // OS-mode HALT answered with a block
    run_txn(K_BLOCK, 2);
    for (int t = 0; t < 1000; t++) begin
      halt_instr = 1'($urandom_range(0, 1));
      tick();
      chk("blocked.HALT", 32'(HALT), 32'd0);
      chk("blocked.cpu_en", 32'(cpu_en), 32'd0);
    end
    halt_instr = 1'b0;

    // Short glitch must not restart
    resume = 1'b1;
    repeat (5) tick();
    resume = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick();
      chk_out("glitch", 1'b0, 1'b0, 1'b0);
    end

    // Bounce every 3 cycles, then a stable press
    for (int t = 0; t < 40; t++) begin
      resume = ((t / 3) % 2 == 0);
      tick();
      chk_out("bounce", 1'b0, 1'b0, 1'b0);
    end
    do_resume();

    // No reaction: timeout, sticky error across resume
    run_txn(K_TIMEOUT, 0);
    do_resume();

    // Block and mode change in the same cycle: block wins
    run_txn(K_BOTH, 3);
    for (int t = 0; t < 5; t++) begin
      tick();
      chk_out("priority", 1'b0, 1'b0, 1'b0);
    end
    do_resume();

    // Randomized transactions
    for (int n = 0; n < 30; n++) begin
      int kind;
      int j;
      kind = int'($urandom_range(0, 3));
      j    = int'($urandom_range(2, 8));
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk_out("rand.idle", 1'b0, 1'b1, 1'b0);
      end
      run_txn(kind, j);
      if (kind != K_SWITCH) do_resume();
    end

    // Asynchronous reset in the middle of a flush
    halt_instr = 1'b1;
    tick();
    halt_instr = 1'b0;
    tick();
    tick();
    Sel_BIOS = ~Sel_BIOS;
    tick();
    tick();
    chk_out("preflush", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    exp_err = 1'b0;
    chk_out("async_reset", 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      chk_out("post_reset", 1'b0, 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
